// File: rtl/pkt_source_gen_pkg.sv
// Shared definitions for the test packet source and future packet checkers.
// Header layout, FSM encoding and the final-word byte-enable helper.
package pkt_source_gen_pkg;

  localparam logic [7:0] HDR_CTRL = 8'hFF;

  localparam int DST_LSB  = 48;
  localparam int WLEN_LSB = 32;
  localparam int SRC_LSB  = 16;
  localparam int BLEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // v = valid bytes in the final word, 1..8
  function automatic logic [7:0] last_ctrl_of(
    input logic [3:0] v
  );
    return 8'h01 << (4'd8 - v);
  endfunction

  function automatic logic [63:0] hdr_word(
    input logic [15:0] dst,
    input logic [15:0] wlen,
    input logic [15:0] src,
    input logic [15:0] blen
  );
    logic [63:0] w;
    w = '0;
    w[DST_LSB  +: 16] = dst;
    w[WLEN_LSB +: 16] = wlen;
    w[SRC_LSB  +: 16] = src;
    w[BLEN_LSB +: 16] = blen;
    return w;
  endfunction

endpackage

// File: rtl/pkt_source_gen_len_calc.sv
// Byte length to word count and final-word ctrl.
// A zero length is treated as a 64-byte packet.
module pkt_len_calc
  import pkt_source_gen_pkg::*;
(
  input  logic [15:0] byte_len,
  output logic [15:0] eff_len,
  output logic [15:0] word_len,
  output logic [7:0]  last_ctrl
);

  logic [16:0] sum;
  logic [3:0]  v;

  always_comb begin
    eff_len   = (byte_len == 16'd0) ? 16'd64 : byte_len;
    sum       = {1'b0, eff_len} + 17'd7;
    word_len  = {2'b00, sum[16:3]};
    v         = (eff_len[2:0] == 3'd0) ? 4'd8
                                       : {1'b0, eff_len[2:0]};
    last_ctrl = last_ctrl_of(v);
  end

endmodule

// File: rtl/pkt_source_gen.sv
// Burst test-packet source on the data/ctrl/wr word interface.
// The word register holds a pending word; out_wr qualifies it with out_rdy.
module pkt_source_gen #(
  parameter int         DATA_WIDTH = 64,
  parameter int         CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int         IPG_CYCLES = 4,
  parameter logic [7:0] HDR_CTRL   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           cfg_byte_len,
  input  logic [15:0]           cfg_pkt_count,
  input  logic [15:0]           cfg_dst_port,
  input  logic [15:0]           cfg_src_port,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pkts_sent
);

  import pkt_source_gen_pkg::*;

  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  state_e       state;
  logic         vld;
  logic [15:0]  len_q;
  logic [15:0]  wl_q;
  logic [7:0]   lc_q;
  logic [15:0]  cnt_q;
  logic [15:0]  dst_q;
  logic [15:0]  src_q;
  logic [31:0]  seq_q;
  logic [15:0]  k_q;
  logic [GW-1:0] gap_q;

  logic [15:0]  cfg_eff;
  logic [15:0]  cfg_wl;
  logic [7:0]   cfg_lc;

  logic         xfer;
  logic         last;
  logic         burst_end;
  logic [15:0]  k_nxt;

  pkt_len_calc u_len (
    .byte_len  (cfg_byte_len),
    .eff_len   (cfg_eff),
    .word_len  (cfg_wl),
    .last_ctrl (cfg_lc)
  );

  assign out_wr    = vld & out_rdy;
  assign xfer      = out_wr;
  assign k_nxt     = k_q + 16'd1;
  assign last      = (k_q == wl_q - 16'd1);
  assign burst_end = (cnt_q != 16'd0) &&
                     (seq_q + 32'd1 == {16'd0, cnt_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      vld       <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
      len_q     <= '0;
      wl_q      <= '0;
      lc_q      <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      seq_q     <= '0;
      k_q       <= '0;
      gap_q     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len_q    <= cfg_eff;
            wl_q     <= cfg_wl;
            lc_q     <= cfg_lc;
            cnt_q    <= cfg_pkt_count;
            dst_q    <= cfg_dst_port;
            src_q    <= cfg_src_port;
            seq_q    <= '0;
            out_data <= hdr_word(cfg_dst_port, cfg_wl,
                                 cfg_src_port, cfg_eff);
            out_ctrl <= HDR_CTRL;
            vld      <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            k_q      <= '0;
            out_data <= {seq_q, 32'd0};
            out_ctrl <= (wl_q == 16'd1) ? lc_q : 8'h00;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer && last) begin
            pkts_sent <= pkts_sent + 32'd1;
            seq_q     <= seq_q + 32'd1;
            if (stop || burst_end) begin
              vld      <= 1'b0;
              out_data <= '0;
              out_ctrl <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else if (IPG_CYCLES > 0) begin
              vld      <= 1'b0;
              out_data <= '0;
              out_ctrl <= '0;
              gap_q    <= GAP_INIT;
              state    <= ST_GAP;
            end else begin
              out_data <= hdr_word(dst_q, wl_q, src_q, len_q);
              out_ctrl <= HDR_CTRL;
              state    <= ST_HDR;
            end
          end else if (xfer) begin
            k_q      <= k_nxt;
            out_data <= {seq_q, 16'd0, k_nxt};
            out_ctrl <= (k_nxt == wl_q - 16'd1) ? lc_q : 8'h00;
          end
        end
        ST_GAP: begin
          if (stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (gap_q == '0) begin
            out_data <= hdr_word(dst_q, wl_q, src_q, len_q);
            out_ctrl <= HDR_CTRL;
            vld      <= 1'b1;
            state    <= ST_HDR;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_source_gen.sv
// Directed bench for pkt_source_gen.
// A reference model fills a word scoreboard; a monitor drains it.
module tb_pkt_source_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] cfg_byte_len;
  logic [15:0] cfg_pkt_count;
  logic [15:0] cfg_dst_port;
  logic [15:0] cfg_src_port;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int viol = 0;
  int idle_run = 0;
  int exp_sent = 0;
  bit rdy_rand = 0;
  logic [71:0] sb[$];
  int gaps[$];

  pkt_source_gen #(.IPG_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_byte_len  (cfg_byte_len),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_dst_port  (cfg_dst_port),
    .cfg_src_port  (cfg_src_port),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .busy          (busy),
    .done          (done),
    .pkts_sent     (pkts_sent)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one packet, written from the word format.
  task automatic push_pkt(input int len, input int seq,
                          input logic [15:0] dst, input logic [15:0] src);
    int l, wl, v;
    logic [7:0] lc;
    logic [7:0] c;
    l  = (len == 0) ? 64 : len;
    wl = (l + 7) / 8;
    v  = l % 8;
    if (v == 0) v = 8;
    lc = 8'h01 << (8 - v);
    sb.push_back({8'hFF, dst, 16'(wl), src, 16'(l)});
    for (int k = 0; k < wl; k++) begin
      c = (k == wl - 1) ? lc : 8'h00;
      sb.push_back({c, 32'(seq), 32'(k)});
    end
    exp_sent++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int maxc);
    int s;
    bit got;
    s = done_cnt;
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (done_cnt != s) got = 1;
    end
    vecs++;
    assert (got) else begin
      errs++;
      $error("FAIL done_timeout: observed no done expected done");
    end
  endtask

  task automatic wait_words(input int n, input int maxc);
    int s;
    bit got;
    s = wr_cnt;
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (wr_cnt - s >= n) got = 1;
    end
    vecs++;
    assert (got) else begin
      errs++;
      $error("FAIL words_timeout: observed %0d expected %0d",
             wr_cnt - s, n);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [71:0] e;
    if (done) done_cnt++;
    if (out_wr && !out_rdy) viol++;
    if (out_wr) begin
      wr_cnt++;
      if (out_ctrl == 8'hFF) gaps.push_back(idle_run);
      idle_run = 0;
      vecs++;
      assert (sb.size() != 0) else begin
        errs++;
        $error("FAIL extra_word: observed %0h expected none",
               {out_ctrl, out_data});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word", {out_ctrl, out_data}, e);
      end
    end else begin
      idle_run++;
    end
  end

  initial begin
    int base;
    reset = 1;
    start = 0;
    stop = 0;
    out_rdy = 1;
    cfg_byte_len = 0;
    cfg_pkt_count = 0;
    cfg_dst_port = 0;
    cfg_src_port = 0;
    #3;
    chk("rst_wr", 72'(out_wr), 72'(0));
    chk("rst_data", 72'(out_data), 72'(0));
    chk("rst_ctrl", 72'(out_ctrl), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_pkts", 72'(pkts_sent), 72'(0));
    step();
    step();
    reset = 0;
    step();

    // L=20, single packet
    cfg_byte_len = 20;
    cfg_pkt_count = 1;
    cfg_dst_port = 16'h0004;
    cfg_src_port = 16'h0001;
    push_pkt(20, 0, 16'h0004, 16'h0001);
    base = wr_cnt;
    pulse_start();
    chk("busy_run", 72'(busy), 72'(1));
    wait_done(100);
    chk("done_1cyc", 72'(done), 72'(0));
    chk("l20_words", 72'(wr_cnt - base), 72'(4));
    chk("l20_sb", 72'(sb.size()), 72'(0));
    chk("l20_pkts", 72'(pkts_sent), 72'(1));
    chk("idle_busy", 72'(busy), 72'(0));

    // L=8 and L=1
    cfg_byte_len = 8;
    push_pkt(8, 0, 16'h0004, 16'h0001);
    pulse_start();
    wait_done(100);
    chk("l8_sb", 72'(sb.size()), 72'(0));
    cfg_byte_len = 1;
    push_pkt(1, 0, 16'h0004, 16'h0001);
    pulse_start();
    wait_done(100);
    chk("l1_sb", 72'(sb.size()), 72'(0));
    chk("l1_pkts", 72'(pkts_sent), 72'(exp_sent));

    // L=64, three packets with inter-packet gap
    cfg_byte_len = 64;
    cfg_pkt_count = 3;
    cfg_dst_port = 16'hABCD;
    cfg_src_port = 16'h1234;
    for (int s = 0; s < 3; s++) push_pkt(64, s, 16'hABCD, 16'h1234);
    gaps.delete();
    base = wr_cnt;
    pulse_start();
    wait_done(300);
    chk("ipg_words", 72'(wr_cnt - base), 72'(27));
    chk("ipg_sb", 72'(sb.size()), 72'(0));
    chk("ipg_hdrs", 72'(gaps.size()), 72'(3));
    if (gaps.size() == 3) begin
      chk("ipg_gap1", 72'(gaps[1]), 72'(4));
      chk("ipg_gap2", 72'(gaps[2]), 72'(4));
    end
    chk("ipg_pkts", 72'(pkts_sent), 72'(exp_sent));

    // Random backpressure, L=100, five packets
    cfg_byte_len = 100;
    cfg_pkt_count = 5;
    cfg_dst_port = 16'h00F0;
    cfg_src_port = 16'h0F00;
    for (int s = 0; s < 5; s++) push_pkt(100, s, 16'h00F0, 16'h0F00);
    viol = 0;
    rdy_rand = 1;
    pulse_start();
    wait_done(2000);
    rdy_rand = 0;
    step();
    out_rdy = 1;
    chk("bp_viol", 72'(viol), 72'(0));
    chk("bp_sb", 72'(sb.size()), 72'(0));
    chk("bp_pkts", 72'(pkts_sent), 72'(exp_sent));

    // Free-running burst stopped during packet 2
    cfg_byte_len = 24;
    cfg_pkt_count = 0;
    cfg_dst_port = 16'h0002;
    cfg_src_port = 16'h0003;
    push_pkt(24, 0, 16'h0002, 16'h0003);
    push_pkt(24, 1, 16'h0002, 16'h0003);
    base = wr_cnt;
    pulse_start();
    wait_words(6, 200);
    stop = 1;
    cfg_byte_len = 200;
    pulse_start();
    wait_done(200);
    stop = 0;
    chk("stop_words", 72'(wr_cnt - base), 72'(8));
    chk("stop_sb", 72'(sb.size()), 72'(0));
    chk("stop_pkts", 72'(pkts_sent), 72'(exp_sent));
    step();
    step();
    chk("stop_idle", 72'(busy), 72'(0));

    // Reset mid-payload
    cfg_byte_len = 64;
    cfg_pkt_count = 1;
    push_pkt(64, 0, 16'h0002, 16'h0003);
    pulse_start();
    wait_words(3, 100);
    #2;
    reset = 1;
    #1;
    chk("arst_wr", 72'(out_wr), 72'(0));
    chk("arst_data", 72'(out_data), 72'(0));
    chk("arst_ctrl", 72'(out_ctrl), 72'(0));
    chk("arst_busy", 72'(busy), 72'(0));
    chk("arst_pkts", 72'(pkts_sent), 72'(0));
    sb.delete();
    exp_sent = 0;
    step();
    step();
    reset = 0;
    base = wr_cnt;
    step();
    step();
    step();
    chk("post_busy", 72'(busy), 72'(0));
    chk("post_words", 72'(wr_cnt - base), 72'(0));
    cfg_byte_len = 8;
    push_pkt(8, 0, 16'h0002, 16'h0003);
    pulse_start();
    wait_done(100);
    chk("post_sb", 72'(sb.size()), 72'(0));
    chk("post_pkts", 72'(pkts_sent), 72'(exp_sent));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
